frame_fifo_sc: RTL
==================

# frame_fifo_sc

Single-clock, parametrised store-and-forward frame FIFO with commit/abort semantics. Sits between a frame producer (MAC RX path, packet builder) and a consumer that must only ever see complete, good frames. A frame becomes visible to the read side when its EOD word is written. Aborted or overflowing frames are rolled back without trace. Generalises the dual-clock frame FIFO in data width and depth, and adds frame drop, rollback and occupancy reporting.

## Interface
- DATA_WIDTH, 8, payload bits per word
- ADDR_WIDTH, 13, depth = 2**ADDR_WIDTH words
- AFULL_CNT, 6660, afull_flag threshold in words (occupancy >= AFULL_CNT)

- clk  in  1  single clock, rising edge
- arst_n  in  1  reset, asynchronous assert, active-low
- di  in  DATA_WIDTH  write data
- we  in  1  write request
- EOD_in  in  1  last word of frame, qualified by we
- abort_in  in  1  discard the frame currently being written
- re  in  1  read request
- do  out  DATA_WIDTH  read data, valid when rvalid
- EOD_out  out  1  last word of frame, valid when rvalid
- rvalid  out  1  do/EOD_out valid, one cycle after an accepted read
- empty_flag  out  1  no committed word available
- full_flag  out  1  occupancy == depth
- afull_flag  out  1  occupancy >= AFULL_CNT
- frame_exist  out  1  at least one committed frame not fully delivered
- level  out  ADDR_WIDTH+1  occupancy in words, including uncommitted words
- drop_cnt  out  16  frames dropped by abort or overflow, saturates at 16'hFFFF

## Operation
- Pointers, all ADDR_WIDTH+1 bits, binary, with an MSB wrap bit:
  - wptr: tentative write pointer.
  - cptr: committed write pointer.
  - rptr: read pointer.
- Memory holds DATA_WIDTH+1 bits per word: {EOD, data}.
- Occupancy: level = wptr - rptr, modulo 2**(ADDR_WIDTH+1).
- full_flag = (level == 2**ADDR_WIDTH).
- empty_flag = (rptr == cptr).
- Write FSM states: ACCEPT, DISCARD.
- Write-side priority (highest first):
  1. abort_in=1 (either state): wptr <= cptr; any word presented this cycle is discarded; drop_cnt++ if wptr != cptr or the state is DISCARD; next state ACCEPT.
  2. ACCEPT, we=1, full_flag=0: write mem[wptr] = {EOD_in, di}; wptr++. If EOD_in=1, then cptr <= wptr+1 (commit).
  3. ACCEPT, we=1, full_flag=1 (overflow): wptr <= cptr; drop_cnt++. If EOD_in=0, next state DISCARD; if EOD_in=1, stay ACCEPT.
  4. DISCARD, we=1: word dropped. If EOD_in=1, next state ACCEPT.
- A frame longer than the depth therefore always overflows and is dropped.
- Read side: a read is accepted when re=1 and empty_flag=0. On acceptance rptr++; the memory is read with a registered output.
  - Next cycle: rvalid=1 and do/EOD_out hold the word.
  - A re while empty is ignored; rvalid=0 the next cycle and do/EOD_out hold their previous values.
- Frame counter fcnt, ADDR_WIDTH+1 bits:
  - +1 on commit.
  - -1 when rvalid & EOD_out.
  - Both in the same cycle: fcnt unchanged.
  - frame_exist = (fcnt != 0).
- Flags are derived from registered state only, with no combinational path from we/re.
- Reads of committed data and writes of an uncommitted frame proceed in the same cycle independently.

## Timing
- Reset values (async): all pointers 0, fcnt 0, state ACCEPT, drop_cnt 0, rvalid 0, do 0, EOD_out 0, empty_flag 1, full_flag 0, afull_flag 0, frame_exist 0, level 0.
- Reset asserted mid-frame or mid-read discards all contents; no partial frame survives.
- Write to visibility: an EOD write accepted at edge N gives empty_flag=0 and frame_exist=1 after edge N, so a read can be accepted at edge N+1.
- Read latency: re accepted at edge N gives data valid after edge N (rvalid high for the cycle N to N+1). Sustained reads run at 1 word/cycle.
- Simultaneous read and write while full: the write is refused, because full is evaluated on pre-edge state. There is no pass-through.
- Pointer wrap: the MSB toggles; full/empty comparisons stay correct across any number of wraps.
- Abort and commit in the same cycle: the abort wins and the EOD word is dropped.
- drop_cnt holds at 16'hFFFF.

## Structure
- Package frame_fifo_pkg holds:
  - write-state encoding (ACCEPT=1'b0, DISCARD=1'b1);
  - DROP_CNT_W=16.
- Sub-module sdp_ram: simple dual-port, one clock, write port plus registered read port, width DATA_WIDTH+1, depth 2**ADDR_WIDTH, infers block RAM.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=4 (depth 16), AFULL_CNT=12.
- Write 5-word frame 0x10..0x14, EOD on 0x14 → frame_exist=1 after the 5th edge; 5 reads return 0x10..0x14 with EOD_out only on 0x14; afterwards empty_flag=1, frame_exist=0.
- Write 3 words, then assert abort_in → level returns to 0, drop_cnt=1, empty_flag stays 1 throughout; a following 2-word frame reads back correctly.
- Write 20-word frame with no reads → full_flag=1 and afull_flag=1 at level 16/12; 17th word overflows, level=0, drop_cnt=1; words 18–20 (EOD on 20) are discarded; the next frame is accepted.
- Commit a 4-word frame, then write an uncommitted 3-word frame while reading → only the 4 committed words are delivered; empty_flag=1 while level=3.
- Stream 10 frames of 3 words with continuous re → pointers wrap; all 30 words arrive in order; fcnt never exceeds 2 when the frame being written is committed in the same cycle as a read EOD.
- Pulse arst_n low mid-frame with a partial frame and one committed frame stored → all outputs return to reset values asynchronously, and nothing is readable afterwards.

Source files
------------

// File: rtl/frame_fifo_pkg.sv
// frame_fifo_pkg: shared write-state encoding and counter widths for the frame FIFO
package frame_fifo_pkg;
  typedef enum logic {
    ACCEPT  = 1'b0,
    DISCARD = 1'b1
  } wr_state_t;
  localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/frame_fifo_sc_sdp_ram.sv
// sdp_ram: single-clock simple dual-port RAM with a registered, read-enabled output
module sdp_ram #(
  parameter int WIDTH      = 9,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
  // write port
  always_ff @(posedge clk)
    if (wen) mem[waddr] <= wdata;
  // read register only loads on an accepted read so the last word is held
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (ren) rdata <= mem[raddr];
endmodule

// File: rtl/frame_fifo_sc.sv
// frame_fifo_sc: store-and-forward frame FIFO with commit/abort rollback and drop counting
module frame_fifo_sc
  import frame_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 13,
  parameter int AFULL_CNT  = 6660
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [DATA_WIDTH-1:0] di,
  input  logic                  we,
  input  logic                  EOD_in,
  input  logic                  abort_in,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  EOD_out,
  output logic                  rvalid,
  output logic                  empty_flag,
  output logic                  full_flag,
  output logic                  afull_flag,
  output logic                  frame_exist,
  output logic [ADDR_WIDTH:0]   level,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  localparam logic [ADDR_WIDTH:0]   ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   AFULL_L  = AFULL_CNT[ADDR_WIDTH:0];
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};
  wr_state_t           state;
  logic [ADDR_WIDTH:0] wptr, cptr, rptr, fcnt;
  logic                wr_en, rd_en, commit, drop, frame_out;
  assign level       = wptr - rptr;
  assign full_flag   = level == DEPTH;
  assign afull_flag  = level >= AFULL_L;
  assign empty_flag  = rptr == cptr;
  assign frame_exist = fcnt != '0;
  assign wr_en       = !abort_in && state == ACCEPT && we && !full_flag;
  assign rd_en       = re && !empty_flag;
  assign commit      = wr_en && EOD_in;
  assign frame_out   = rvalid && EOD_out;
  // a frame is dropped on abort of real content, or on a write that hits a full FIFO
  assign drop = abort_in ? (wptr != cptr || state == DISCARD)
                         : (we && state == ACCEPT && full_flag);
  // write side: tentative pointer, commit pointer, discard state and drop counter
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state    <= ACCEPT;
      wptr     <= '0;
      cptr     <= '0;
      drop_cnt <= '0;
    end else begin
      if (abort_in) begin
        wptr  <= cptr;
        state <= ACCEPT;
      end else if (wr_en) begin
        wptr <= wptr + ONE;
        if (EOD_in) cptr <= wptr + ONE;
      end else if (we && state == ACCEPT) begin
        wptr <= cptr;
        if (!EOD_in) state <= DISCARD;
      end else if (we && EOD_in) state <= ACCEPT;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_ONE;
    end
  // read side: read pointer, output valid and count of frames not yet fully delivered
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      rptr   <= '0;
      rvalid <= 1'b0;
      fcnt   <= '0;
    end else begin
      if (rd_en) rptr <= rptr + ONE;
      rvalid <= rd_en;
      fcnt   <= (commit && !frame_out) ? fcnt + ONE :
                (frame_out && !commit) ? fcnt - ONE : fcnt;
    end
  sdp_ram #(
    .WIDTH      (DATA_WIDTH + 1),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (arst_n),
    .wen   (wr_en),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata ({EOD_in, di}),
    .ren   (rd_en),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata ({EOD_out, dout})
  );
endmodule
